mssd_frame_scheduler: RTL and testbench
=======================================

// Module: mssd_frame_scheduler
// PURPOSE
// - Shares the single MSSD serial line among 4 requesters; output serOut drives serIn of the MSSD demultiplexer.
// - Round-robin grants one requester at a time, then serializes its frame:
//   start bit, 2-bit port id, 4-bit length, N payload bits.
// - Pulses ack to the owner when its frame completes; enforces an idle gap between frames.
// PARAMETERS
// - DATA_W   16  payload register width per requester; must be >= 15
// - GAP_CYC  1   idle-high cycles after every frame; must be >= 1
// PORTS
// - clk         in   1            single clock, all state on rising edge
// - rst         in   1            asynchronous, active-high reset
// - req         in   4            req[i]=1: requester i has a frame pending; held until ack[i]
// - len         in   4x4          len[i]: payload bit count N (0..15) for requester i
// - data        in   4xDATA_W     data[i]: payload for requester i, bit 0 sent first
// - ack         out  4            one-cycle pulse to the requester whose frame just finished
// - serOut      out  1            serial line; idles at 1
// - busy        out  1            1 from start bit through last gap cycle
// - activePort  out  2            index of current or last granted requester
// BEHAVIOUR
// - Reset (async, immediate): serOut=1, busy=0, ack=0, activePort=0, rr pointer=0, state IDLE.
//   Reset mid-frame aborts the frame. No ack is issued; the requester keeps req high and is re-served later.
// - FSM states: IDLE -> START -> PORT -> LEN -> DATA -> GAP -> IDLE. Bit counter cnt is 4 bits.
// - IDLE: serOut=1, busy=0. On an edge with req!=0:
//   - grant the first requesting port at or after rr pointer, wrapping 3->0;
//   - capture len and data of the granted port into shadow registers;
//   - set activePort; go to START.
//   - Later changes to len/data are ignored until the next grant.
// - START: serOut=0 for 1 cycle. PORT: 2 cycles, port id MSB first. LEN: 4 cycles, N MSB first.
// - DATA: N cycles, shadow bit 0 first, shift right each cycle. N=0 skips DATA (LEN -> GAP).
// - Latency: req seen at edge k -> start bit on serOut during cycle k+1. Frame occupies 7+N cycles, then the gap.
// - GAP: serOut=1, busy=1 for GAP_CYC cycles.
//   - ack[granted]=1 during the first GAP cycle only.
//   - rr pointer <= granted+1 (mod 4) on entry to GAP.
// - Requester contract: deassert req (or present a new frame) by the edge ending the first GAP cycle.
//   req still high when IDLE is re-entered is treated as a new frame.
// - req changes while busy have no effect on the current frame. At most one ack bit set at any time.
// - Simultaneous requests: strict rotation; a continuously requesting port waits at most 3 frames.
// - len values >15 are not representable; shadow data bits above N-1 are never transmitted.
// - serOut, ack and busy are registered outputs with no combinational path from the inputs.
// STRUCTURE
// - mssd_pkg (shared with the MSSD demux):
//   - PORT_W=2, LEN_W=4, IDLE_LEVEL=1'b1, START_LEVEL=1'b0;
//   - typedef enum {IDLE,START,PORT,LEN,DATA,GAP} sched_state_t;
//   - typedef logic [LEN_W-1:0] mssd_len_t.
// - Sub-module mssd_rr_arbiter: inputs req[3:0] and ptr[1:0]; outputs gnt_idx[1:0] and gnt_valid.
//   Combinational priority rotate. The FSM, counter and shifter stay in this module.
// TESTING
// - Reset, then req=0 for 10 cycles -> serOut=1, busy=0, ack=0 throughout.
// - req=4'b0100, len[2]=5, data[2]=16'h0015 -> serOut 0,1,0,0,1,0,1,1,0,1,0,1.
//   ack[2] pulses in the cycle after the last bit; activePort=2.
// - req=4'b1111, all len=1, hold each req until its own ack ->
//   - grants in order 0,1,2,3;
//   - each frame 8 cycles + 1 gap;
//   - ack pulses are 9 cycles apart.
// - req=4'b0010, len[1]=0 -> 7-cycle frame 0,0,1,0,0,0,0, then ack[1]; no payload cycles.
// - Assert rst during DATA of a len=15 frame -> serOut=1 immediately, no ack.
//   After release with req still high, the frame restarts from START using pointer 0.
// - Change data[3] one cycle after grant of port 3 -> transmitted payload equals the value captured at grant.

Source files
------------

// File: rtl/mssd_pkg.sv
// Shared MSSD definitions, used by both the frame scheduler and the MSSD demux.
// Frame on the wire: start bit, port id (MSB first), payload length (MSB first),
// then the payload, LSB first.
package mssd_pkg;

    localparam int unsigned PORT_W  = 2;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned N_PORTS = 4;
    localparam int unsigned HDR_W   = PORT_W + LEN_W;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GAP} sched_state_t;

    typedef logic [LEN_W-1:0]  mssd_len_t;
    typedef logic [PORT_W-1:0] mssd_port_t;

    // Frame header latched at grant time
    typedef struct packed {
        mssd_port_t port;
        mssd_len_t  len;
    } mssd_hdr_t;

endpackage

// File: rtl/mssd_rr_arbiter.sv
// Round-robin priority rotate: grants the first requesting port at or after ptr,
// wrapping from the highest port back to 0.
// Ports:
//   req       - per-port request vector
//   ptr       - port with highest priority this round
//   gnt_idx   - granted port (combinational)
//   gnt_valid - at least one request present (combinational)
module mssd_rr_arbiter
    import mssd_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  mssd_port_t         ptr,
    output mssd_port_t         gnt_idx,
    output logic               gnt_valid
);

    mssd_port_t cand;

    // Scan from the farthest candidate down to ptr so the nearest requester wins
    always_comb begin
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = ptr + PORT_W'(k);
            if (req[cand]) begin
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mssd_frame_scheduler.sv
// Shares the single MSSD serial line among four requesters. A round-robin grant
// picks one requester, its length/payload are captured, and the frame is sent as
// start bit, port id, length, payload; ack pulses in the first idle-gap cycle.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   req         - per-requester frame pending, held until its ack
//   len, data   - per-requester payload bit count and payload (bit 0 first)
//   ack         - one-cycle completion pulse to the frame owner
//   serOut      - serial line to the MSSD demux, idles high
//   busy        - high from start bit through the last gap cycle
//   activePort  - current or most recently granted requester
module mssd_frame_scheduler
    import mssd_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              req,
    input  logic [N_PORTS-1:0][LEN_W-1:0]   len,
    input  logic [N_PORTS-1:0][DATA_W-1:0]  data,
    output logic [N_PORTS-1:0]              ack,
    output logic                            serOut,
    output logic                            busy,
    output logic [PORT_W-1:0]               activePort
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    sched_state_t        state_q, state_d;
    mssd_len_t           cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    mssd_hdr_t           hdr_q, hdr_d;
    logic [HDR_W-1:0]    hsh_q, hsh_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    mssd_port_t          rr_q, rr_d;
    logic                ser_q, ser_d;
    logic                busy_q, busy_d;
    logic [N_PORTS-1:0]  ack_q, ack_d;

    mssd_port_t          gnt_idx;
    logic                gnt_valid;
    logic                grant_ok;
    logic                enter_gap;

    mssd_rr_arbiter u_arb (
        .req       (req),
        .ptr       (rr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Next-state and next-output logic; outputs are the registered values of
    // what the line must show in the following cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        hdr_d     = hdr_q;
        hsh_d     = hsh_q;
        shift_d   = shift_q;
        rr_d      = rr_q;
        ser_d     = IDLE_LEVEL;
        busy_d    = 1'b1;
        ack_d     = '0;
        grant_ok  = 1'b0;
        enter_gap = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                grant_ok = 1'b1;
            end
            START: begin
                state_d = PORT;
                cnt_d   = '0;
                ser_d   = hsh_q[HDR_W-1];
                hsh_d   = hsh_q << 1;
            end
            PORT: begin
                ser_d = hsh_q[HDR_W-1];
                hsh_d = hsh_q << 1;
                if (cnt_q == LEN_W'(PORT_W - 1)) begin
                    state_d = LEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            LEN: begin
                if (cnt_q != LEN_W'(LEN_W - 1)) begin
                    ser_d = hsh_q[HDR_W-1];
                    hsh_d = hsh_q << 1;
                    cnt_d = cnt_q + LEN_W'(1);
                end else if (hdr_q.len == '0) begin
                    enter_gap = 1'b1;
                end else begin
                    state_d = DATA;
                    cnt_d   = '0;
                    ser_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (cnt_q == hdr_q.len - LEN_W'(1)) begin
                    enter_gap = 1'b1;
                end else begin
                    ser_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + LEN_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    grant_ok = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (enter_gap) begin
            state_d           = GAP;
            gap_d             = '0;
            ack_d[hdr_q.port] = 1'b1;
            rr_d              = hdr_q.port + PORT_W'(1);
        end

        // Arbitration happens in IDLE and on the last gap cycle, so back-to-back
        // frames are separated by exactly GAP_CYC idle-high cycles.
        if (grant_ok) begin
            if (gnt_valid) begin
                state_d    = START;
                cnt_d      = '0;
                ser_d      = START_LEVEL;
                busy_d     = 1'b1;
                hdr_d.port = gnt_idx;
                hdr_d.len  = len[gnt_idx];
                hsh_d      = {gnt_idx, len[gnt_idx]};
                shift_d    = data[gnt_idx];
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            hdr_q   <= '0;
            hsh_q   <= '0;
            shift_q <= '0;
            rr_q    <= '0;
            ser_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            hdr_q   <= hdr_d;
            hsh_q   <= hsh_d;
            shift_q <= shift_d;
            rr_q    <= rr_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign serOut     = ser_q;
    assign busy       = busy_q;
    assign ack        = ack_q;
    assign activePort = hdr_q.port;

endmodule

// File: tb/tb_mssd_frame_scheduler.sv
// Scoreboard bench for mssd_frame_scheduler: stimulus pushes the expected frame
// (port, bit count, serial bit string) and a monitor collects serOut while busy,
// comparing against the queue head whenever ack pulses.
module tb_mssd_frame_scheduler;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned MAXB   = 22;

    typedef struct {
        int              port;
        int              nbits;
        logic [MAXB-1:0] bits;   // first-sent bit is the MSB of the low nbits
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             req;
    logic [3:0][3:0]        len;
    logic [3:0][DATA_W-1:0] data;
    logic [3:0]             ack;
    logic                   serOut;
    logic                   busy;
    logic [1:0]             activePort;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   ack_cyc[$];

    mssd_frame_scheduler #(.DATA_W(DATA_W), .GAP_CYC(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .len        (len),
        .data       (data),
        .ack        (ack),
        .serOut     (serOut),
        .busy       (busy),
        .activePort (activePort)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk_hand(input int port, input int nbits, input logic [MAXB-1:0] bits);
        exp_t e;
        e.port  = port;
        e.nbits = nbits;
        e.bits  = bits;
        return e;
    endfunction

    // Reference frame builder: start, port MSB first, len MSB first, payload LSB first
    function automatic exp_t mk(input int port, input int n, input logic [DATA_W-1:0] d);
        exp_t       e;
        logic [1:0] p;
        logic [3:0] l;
        p       = 2'(port);
        l       = 4'(n);
        e.port  = port;
        e.nbits = 7 + n;
        e.bits  = '0;
        e.bits  = {e.bits[MAXB-2:0], 1'b0};
        for (int i = 1; i >= 0; i--) e.bits = {e.bits[MAXB-2:0], p[i]};
        for (int i = 3; i >= 0; i--) e.bits = {e.bits[MAXB-2:0], l[i]};
        for (int i = 0; i < n; i++)  e.bits = {e.bits[MAXB-2:0], d[i]};
        return e;
    endfunction

    // Monitor: collect line bits while busy, score the frame on ack
    initial begin
        logic [MAXB-1:0] got_bits;
        int              got_n;
        exp_t            e;
        got_bits = '0;
        got_n    = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                got_bits = '0;
                got_n    = 0;
            end else if (ack != 4'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vector", 32'(ack), 32'(4'b0001 << e.port));
                    check("active_port", 32'(activePort), 32'(e.port));
                    check("frame_len", 32'(got_n), 32'(e.nbits));
                    check("frame_bits", 32'(got_bits), 32'(e.bits));
                end
                ack_cyc.push_back(cyc);
                got_bits = '0;
                got_n    = 0;
            end else if (busy) begin
                if (got_n < int'(MAXB)) begin
                    got_bits = {got_bits[MAXB-2:0], serOut};
                    got_n++;
                end
            end
        end
    end

    // Requester model: drop each req bit as soon as its ack is seen
    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(posedge clk);
            #1;
            if (ack != 4'b0) begin
                req = req & ~ack;
                got++;
            end
        end
        check("ack_count", 32'(got), 32'(n));
    endtask

    task automatic wait_busy(input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (busy) seen = 1;
        end
        check("grant_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst  = 1'b1;
        req  = '0;
        len  = '0;
        data = '0;
        #1;
        check("rst_ser", 32'(serOut), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_port", 32'(activePort), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Idle line with no requests
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_ser", 32'(serOut), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ack", 32'(ack), 32'd0);
        end

        // All four request at once, len 1 each: grants 0,1,2,3, acks 9 cycles apart
        len     = {4'd1, 4'd1, 4'd1, 4'd1};
        data[0] = 16'h0001;
        data[1] = 16'h0000;
        data[2] = 16'h0003;
        data[3] = 16'h0002;
        for (int i = 0; i < 4; i++) sb.push_back(mk(i, 1, data[i]));
        base = ack_cyc.size();
        req  = 4'b1111;
        wait_acks(4, 200);
        repeat (2) @(posedge clk);
        if (ack_cyc.size() >= base + 4) begin
            for (int k = 0; k < 3; k++)
                check("ack_spacing", 32'(ack_cyc[base+k+1] - ack_cyc[base+k]), 32'd9);
        end
        #1;

        // Single request, port 2, len 5, payload 0x15
        len[2]  = 4'd5;
        data[2] = 16'h0015;
        sb.push_back(mk_hand(2, 12, 22'b0100_1011_0101));
        req = 4'b0100;
        wait_acks(1, 50);
        repeat (2) @(posedge clk);
        #1;

        // Zero-length frame from port 1
        len[1] = 4'd0;
        sb.push_back(mk_hand(1, 7, 22'b001_0000));
        req = 4'b0010;
        wait_acks(1, 50);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a len-15 payload; pointer returns to 0 afterwards
        len[0]  = 4'd15;
        data[0] = 16'h1234;
        len[2]  = 4'd15;
        data[2] = 16'hBEEF;
        req     = 4'b0101;
        wait_busy(20);
        check("grant_after_ptr2", 32'(activePort), 32'd2);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ser", 32'(serOut), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_port", 32'(activePort), 32'd0);
        sb.push_back(mk(0, 15, 16'h1234));
        sb.push_back(mk(2, 15, 16'hBEEF));
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_acks(2, 100);
        repeat (2) @(posedge clk);
        #1;

        // Payload change after grant is not transmitted
        len[3]  = 4'd8;
        data[3] = 16'h5A3C;
        sb.push_back(mk(3, 8, 16'h5A3C));
        req = 4'b1000;
        wait_busy(20);
        @(posedge clk);
        #1;
        data[3] = 16'hFFFF;
        len[3]  = 4'd15;
        wait_acks(1, 50);
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("final_idle_busy", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
